// File: rtl/gfx_pkg.sv
// Shared helpers for the graphics-path PAL-replacement blocks.
package gfx_pkg;
    localparam int PLANES_DEF = 4;
    localparam int PPW_DEF    = 4;
    localparam int WCNTW_DEF  = 6;
    localparam int PIX_W      = PLANES_DEF;
    localparam int WORD_W     = PLANES_DEF * PPW_DEF;

    // Lowest bit of plane p's slice within a ROM word.
    function automatic int slice_lo(input int p, input int ppw);
        return p * ppw;
    endfunction
endpackage

// File: rtl/cen_edge.sv
// Rising-edge detector for a clock enable; one tick per Cen rising edge.
module cen_edge (
    input  logic clk,
    input  logic Reset,
    input  logic cen,
    output logic tick
);
    logic cen_q;

    // Resetting to 1 stops a Cen held high through reset from ticking.
    always_ff @(posedge clk) begin
        if (Reset) cen_q <= 1'b1;
        else       cen_q <= cen;
    end

    assign tick = cen & ~cen_q;
endmodule

// File: rtl/gfx_shift_sequencer.sv
// Bit-plane pixel serialiser: loads ROM words, shifts PPW pixels out per word.
module gfx_shift_sequencer
    import gfx_pkg::*;
#(
    parameter int PLANES = PLANES_DEF,
    parameter int PPW    = PPW_DEF,
    parameter int WCNTW  = WCNTW_DEF
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Cen,
    input  logic                  active,
    input  logic                  flip,
    input  logic [PLANES*PPW-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ack,
    output logic [PLANES-1:0]     pixel,
    output logic                  pix_en,
    output logic                  load_strobe,
    output logic                  bank_sel,
    output logic [WCNTW-1:0]      word_cnt,
    output logic                  underrun,
    input  logic                  clr_underrun
);
    localparam int CNT_W = (PPW > 2) ? $clog2(PPW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PPW - 1);

    logic                  tick;
    logic [PLANES*PPW-1:0] sreg, sreg_shift;
    logic [CNT_W-1:0]      cnt;
    logic                  flip_q, valid_q, active_q;
    logic [PLANES-1:0]     pix_raw;
    logic                  load, underrun_set;

    cen_edge u_cen_edge (
        .clk   (clk),
        .Reset (Reset),
        .cen   (Cen),
        .tick  (tick)
    );

    for (genvar p = 0; p < PLANES; p++) begin : g_plane
        localparam int LO = slice_lo(p, PPW);
        assign sreg_shift[LO +: PPW] = flip_q ? {1'b0, sreg[LO+1 +: PPW-1]}
                                              : {sreg[LO +: PPW-1], 1'b0};
        assign pix_raw[p] = flip_q ? sreg[LO] : sreg[LO+PPW-1];
    end

    assign load         = tick & active & (cnt == CNT_LAST);
    assign underrun_set = load & ~data_valid;

    always_ff @(posedge clk) begin
        if (Reset) begin
            sreg        <= '0;
            cnt         <= CNT_LAST;
            bank_sel    <= 1'b0;
            word_cnt    <= '0;
            flip_q      <= 1'b0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            data_ack    <= 1'b0;
            load_strobe <= 1'b0;
        end else begin
            data_ack    <= 1'b0;
            load_strobe <= 1'b0;
            if (tick) begin
                active_q <= active;
                if (!active) begin
                    // Blanking keeps sreg; the next active tick reloads anyway.
                    cnt      <= CNT_LAST;
                    valid_q  <= 1'b0;
                    word_cnt <= '0;
                end else if (load) begin
                    cnt         <= '0;
                    bank_sel    <= ~bank_sel;
                    word_cnt    <= word_cnt + 1'b1;
                    flip_q      <= flip;
                    load_strobe <= 1'b1;
                    valid_q     <= data_valid;
                    data_ack    <= data_valid;
                    sreg        <= data_valid ? data_in : '0;
                end else begin
                    cnt  <= cnt + 1'b1;
                    sreg <= sreg_shift;
                end
            end
        end
    end

    // A new underrun outranks a clear arriving on the same clk.
    always_ff @(posedge clk) begin
        if (Reset)             underrun <= 1'b0;
        else if (underrun_set) underrun <= 1'b1;
        else if (clr_underrun) underrun <= 1'b0;
    end

    assign pix_en = valid_q & active_q;
    assign pixel  = pix_en ? pix_raw : '0;
endmodule

// File: tb/tb_gfx_shift_sequencer.sv
// Directed self-checking bench for gfx_shift_sequencer (PLANES=4, PPW=4).
module tb_gfx_shift_sequencer;
    logic        clk = 1'b0;
    logic        Reset, Cen, active, flip, data_valid, clr_underrun;
    logic [15:0] data_in;
    logic        data_ack, pix_en, load_strobe, bank_sel, underrun;
    logic [3:0]  pixel;
    logic [5:0]  word_cnt;

    int checks   = 0;
    int failures = 0;

    // Hand-derived pixels for 16'hA5C3: pixel[p] = data_in[4p+3-k].
    logic [3:0] a5c3_fwd [4] = '{4'b1010, 4'b0110, 4'b1001, 4'b0101};

    gfx_shift_sequencer dut (
        .clk          (clk),
        .Reset        (Reset),
        .Cen          (Cen),
        .active       (active),
        .flip         (flip),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ack     (data_ack),
        .pixel        (pixel),
        .pix_en       (pix_en),
        .load_strobe  (load_strobe),
        .bank_sel     (bank_sel),
        .word_cnt     (word_cnt),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One Cen rising edge; returns at the negedge after the ticking posedge.
    task automatic do_tick;
        @(negedge clk) Cen = 1'b0;
        @(negedge clk) Cen = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_ack"},   data_ack,    1'b0);
        check({tag, "_strb"},  load_strobe, 1'b0);
        check({tag, "_pixen"}, pix_en,      1'b0);
        check({tag, "_pix"},   pixel,       4'h0);
        check({tag, "_bank"},  bank_sel,    1'b0);
        check({tag, "_wcnt"},  word_cnt,    6'd0);
        check({tag, "_undr"},  underrun,    1'b0);
    endtask

    initial begin
        int acks;
        Reset = 1'b1; Cen = 1'b1; active = 1'b0; flip = 1'b0;
        data_valid = 1'b0; clr_underrun = 1'b0; data_in = 16'h0;
        repeat (3) @(negedge clk);
        active = 1'b1; data_valid = 1'b1; data_in = 16'hA5C3;
        Reset = 1'b0;
        @(negedge clk);
        chk_reset("rst");
        @(negedge clk);
        check("no_tick_held_cen", load_strobe | data_ack, 1'b0);

        // Word 1: A5C3, forward.
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            do_tick();
            acks += int'(data_ack);
            check($sformatf("fwd_pix%0d", k), pixel, a5c3_fwd[k]);
            check($sformatf("fwd_en%0d", k), pix_en, 1'b1);
            check($sformatf("fwd_strb%0d", k), load_strobe, k == 0);
            if (k == 0) check("fwd_ack_first", data_ack, 1'b1);
        end
        check("fwd_ack_count", acks, 1);
        check("fwd_bank", bank_sel, 1'b1);
        check("fwd_wcnt", word_cnt, 6'd1);

        // Word 2: A5C3 mirrored; flip toggled mid-word must not matter.
        flip = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) flip = 1'b0;
            do_tick();
            check($sformatf("flip_pix%0d", k), pixel, a5c3_fwd[3-k]);
        end
        check("flip_bank", bank_sel, 1'b0);
        check("flip_wcnt", word_cnt, 6'd2);

        // Back-to-back FFFF then 0000.
        data_in = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            do_tick();
            check($sformatf("ff_pix%0d", k), pixel, 4'hF);
        end
        check("ff_bank", bank_sel, 1'b1);
        check("ff_wcnt", word_cnt, 6'd3);
        data_in = 16'h0000;
        do_tick();
        check("zz_ack", data_ack, 1'b1);
        check("zz_pix", pixel, 4'h0);
        check("zz_en", pix_en, 1'b1);
        check("zz_bank", bank_sel, 1'b0);
        check("zz_wcnt", word_cnt, 6'd4);
        repeat (3) do_tick();

        // Underrun on the next load.
        data_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_tick();
            check($sformatf("ur_en%0d", k), pix_en, 1'b0);
            check($sformatf("ur_pix%0d", k), pixel, 4'h0);
            check($sformatf("ur_ack%0d", k), data_ack, 1'b0);
            check($sformatf("ur_flag%0d", k), underrun, 1'b1);
        end
        check("ur_strobe_wcnt", word_cnt, 6'd5);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        check("ur_clear", underrun, 1'b0);
        clr_underrun = 1'b1;
        do_tick();
        clr_underrun = 1'b0;
        check("ur_set_beats_clr", underrun, 1'b1);
        check("ur_load_strobe", load_strobe, 1'b1);
        repeat (3) do_tick();

        // Blank at k=1 for 3 ticks, then active reload.
        data_valid = 1'b1; data_in = 16'hA5C3;
        do_tick();
        do_tick();
        check("pre_blank_pix", pixel, a5c3_fwd[1]);
        active = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_tick();
            check($sformatf("blank_en%0d", k), pix_en, 1'b0);
            check($sformatf("blank_pix%0d", k), pixel, 4'h0);
            check($sformatf("blank_wcnt%0d", k), word_cnt, 6'd0);
        end
        active = 1'b1;
        do_tick();
        check("unblank_ack", data_ack, 1'b1);
        check("unblank_wcnt", word_cnt, 6'd1);
        check("unblank_pix", pixel, a5c3_fwd[0]);
        repeat (3) do_tick();

        // Cen held high 5 clks: single tick, one-clk pulses.
        @(negedge clk) Cen = 1'b0;
        @(negedge clk) Cen = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold_ack%0d", c), data_ack, c == 0);
            check($sformatf("hold_strb%0d", c), load_strobe, c == 0);
            check($sformatf("hold_pix%0d", c), pixel, a5c3_fwd[0]);
        end
        do_tick();
        check("hold_next_pix", pixel, a5c3_fwd[1]);

        // Reset mid-word.
        clr_underrun = 1'b0;
        Reset = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        Reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
